stage_sequencer: RTL



---
 rtl/stage_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Central phase controller for the multicycle datapath. One phase counter
//   per instruction period. It issues one-cycle stage strobes at fixed
//   phases. It supports start, stall and graceful halt, and it counts
//   retired instructions.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        begin/resume sequencing (level, honoured in IDLE/HALTED)
//   stall        freeze phase and suppress strobes while high
//   halt         request stop at end of current instruction (pulse or level)
//   phase        current phase, 0..PERIOD-1
//   en_if/id/ex/mem/wb  stage strobes
//   busy         high in RUN
//   done         high in HALTED
//   instr_count  retired instructions (wraps mod 2^IC_W)

// Per-stage strobe decode: high while the sequencer may fire and the phase
// matches this stage's slot.
module strobe_dec #(
  parameter int              CNT_W = 4,
  parameter logic [CNT_W-1:0] PH   = '0
) (
  input  logic             fire_ok,
  input  logic [CNT_W-1:0] phase,
  output logic             en
);
  assign en = fire_ok && (phase == PH);
endmodule

module stage_sequencer #(
  parameter int PERIOD = 10,
  parameter int PH_IF  = 1,
  parameter int PH_ID  = 2,
  parameter int PH_EX  = 3,
  parameter int PH_MEM = 4,
  parameter int PH_WB  = 5,
  parameter int CNT_W  = 4,
  parameter int IC_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  output logic [CNT_W-1:0] phase,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             busy,
  output logic             done,
  output logic [IC_W-1:0]  instr_count
);

  localparam int NUM_STB = 5;
  localparam int PH_TAB [NUM_STB] = '{PH_IF, PH_ID, PH_EX, PH_MEM, PH_WB};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  localparam bit PARAMS_OK =
    (PERIOD >= 1) && ((64'd1 << CNT_W) >= 64'(PERIOD)) &&
    (PH_IF  >= 0) && (PH_IF  < PERIOD) &&
    (PH_ID  >= 0) && (PH_ID  < PERIOD) &&
    (PH_EX  >= 0) && (PH_EX  < PERIOD) &&
    (PH_MEM >= 0) && (PH_MEM < PERIOD) &&
    (PH_WB  >= 0) && (PH_WB  < PERIOD) &&
    (PH_IF != PH_ID)  && (PH_IF != PH_EX)  && (PH_IF != PH_MEM) &&
    (PH_IF != PH_WB)  && (PH_ID != PH_EX)  && (PH_ID != PH_MEM) &&
    (PH_ID != PH_WB)  && (PH_EX != PH_MEM) && (PH_EX != PH_WB)  &&
    (PH_MEM != PH_WB);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;
  logic   halt_pending;
  logic   hp_eff;
  logic   fire_ok;
  logic [NUM_STB-1:0] stb;

  // A halt arriving in the wrap cycle counts as already pending.
  assign hp_eff = halt_pending | halt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      halt_pending <= 1'b0;
      instr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (stall) begin
            // Phase and count frozen; halt still latched so it is not lost.
            if (halt) halt_pending <= 1'b1;
          end else if (phase == LAST) begin
            phase       <= '0;
            instr_count <= instr_count + 1'b1;
            if (hp_eff) begin
              state        <= HALTED;
              halt_pending <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            if (halt) halt_pending <= 1'b1;
          end
        end
        HALTED: begin
          phase        <= '0;
          halt_pending <= 1'b0;
          if (start) state <= RUN;
        end
        default: begin
          state        <= IDLE;
          phase        <= '0;
          halt_pending <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are a decode of registered state/phase, masked by stall and by
  // reset so an abandoned instruction never fires in the reset cycle.
  assign fire_ok = (state == RUN) && !stall && !reset;

  for (genvar i = 0; i < NUM_STB; i++) begin : g_stb
    strobe_dec #(
      .CNT_W (CNT_W),
      .PH    (CNT_W'(PH_TAB[i]))
    ) u_dec (
      .fire_ok (fire_ok),
      .phase   (phase),
      .en      (stb[i])
    );
  end

  assign en_if  = stb[0];
  assign en_id  = stb[1];
  assign en_ex  = stb[2];
  assign en_mem = stb[3];
  assign en_wb  = stb[4];

  assign busy = (state == RUN);
  assign done = (state == HALTED);

  // Simulation-only parameter legality check.
  always_ff @(posedge clock) begin
    assert (PARAMS_OK)
      else $error("stage_sequencer: illegal PERIOD/PH_X/CNT_W parameters");
  end

endmodule
